// File: rtl/dram_result_dumper.sv
// Post-run data-memory dumper: once all cores halt, borrows the data_mem read
// port, streams a fixed address window over a valid/ready byte interface and
// keeps a running modular checksum of everything sent.
module dram_result_dumper #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DUMP_BASE = 0,
    parameter int unsigned DUMP_LEN  = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             proc_state,
    output logic             mem_sel,
    output logic             mem_rEn,
    output logic [WIDTH-1:0] mem_addr,
    input  logic [WIDTH-1:0] mem_data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_last,
    output logic             dump_done,
    output logic [WIDTH-1:0] checksum
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StReq  = 3'd1;
    localparam logic [2:0] StWait = 3'd2;
    localparam logic [2:0] StSend = 3'd3;
    localparam logic [2:0] StDone = 3'd4;

    // Index is one bit wider than the address so a full 2^WIDTH window is legal.
    localparam logic [WIDTH:0]   LastIdx = (WIDTH+1)'(DUMP_LEN - 1);
    localparam logic [WIDTH-1:0] Base    = WIDTH'(DUMP_BASE);

    logic [2:0]       state_q, state_d;
    logic [WIDTH:0]   index_q, index_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] sum_q, sum_d;

    // Next-state logic: one memory read per word, word held until accepted.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        data_d  = data_q;
        last_d  = last_q;
        sum_d   = sum_q;
        case (state_q)
            StIdle: begin
                if (proc_state) begin
                    state_d = StReq;
                    index_d = '0;
                    sum_d   = '0;
                    data_d  = '0;
                    last_d  = 1'b0;
                end
            end
            StReq: begin
                state_d = StWait;
            end
            StWait: begin
                // mem_data is registered, so it is valid the cycle after rEn.
                data_d  = mem_data;
                sum_d   = sum_q + mem_data;
                last_d  = (index_q == LastIdx);
                state_d = StSend;
            end
            StSend: begin
                if (out_ready) begin
                    if (last_q) begin
                        state_d = StDone;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = StReq;
                    end
                end
            end
            StDone: begin
                // Re-arm only after the halt flag drops; clear so IDLE reads all-zero.
                if (!proc_state) begin
                    state_d = StIdle;
                    index_d = '0;
                    sum_d   = '0;
                    data_d  = '0;
                    last_d  = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous abort on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            index_q <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            data_q  <= data_d;
            last_q  <= last_d;
            sum_q   <= sum_d;
        end
    end

    // Outputs decoded from state; port ownership released outside the dump.
    always_comb begin
        mem_sel   = (state_q == StReq) || (state_q == StWait) || (state_q == StSend);
        mem_rEn   = (state_q == StReq);
        mem_addr  = (state_q == StReq) ? (Base + index_q[WIDTH-1:0]) : '0;
        out_valid = (state_q == StSend);
        out_last  = (state_q == StSend) && last_q;
        dump_done = (state_q == StDone);
        out_data  = data_q;
        checksum  = sum_q;
    end

endmodule

// File: tb/tb_dram_result_dumper.sv
// Directed bench for dram_result_dumper: a default instance (base 0, len 16)
// and a wrap-around instance (base 254, len 4), each with its own data_mem model.
module tb_dram_result_dumper;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        logic       last;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, ps0, ps1, ready, sel;

    logic       sel0, ren0, valid0, last0, done0;
    logic [7:0] addr0, mdata0, data0, sum0;
    logic       sel1, ren1, valid1, last1, done1;
    logic [7:0] addr1, mdata1, data1, sum1;

    logic [7:0] mem0 [256];
    logic [7:0] mem1 [256];

    dram_result_dumper #(.WIDTH(8), .DUMP_BASE(0), .DUMP_LEN(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .proc_state(ps0),
        .mem_sel(sel0), .mem_rEn(ren0), .mem_addr(addr0), .mem_data(mdata0),
        .out_data(data0), .out_valid(valid0), .out_ready(ready), .out_last(last0),
        .dump_done(done0), .checksum(sum0)
    );

    dram_result_dumper #(.WIDTH(8), .DUMP_BASE(254), .DUMP_LEN(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .proc_state(ps1),
        .mem_sel(sel1), .mem_rEn(ren1), .mem_addr(addr1), .mem_data(mdata1),
        .out_data(data1), .out_valid(valid1), .out_ready(ready), .out_last(last1),
        .dump_done(done1), .checksum(sum1)
    );

    // Registered-read memory models.
    always @(posedge clk) if (ren0) mdata0 <= mem0[addr0];
    always @(posedge clk) if (ren1) mdata1 <= mem1[addr1];

    // View of whichever instance is under test.
    logic       d_sel, d_ren, d_valid, d_last, d_done;
    logic [7:0] d_addr, d_data, d_sum;
    assign d_sel   = sel ? sel1   : sel0;
    assign d_ren   = sel ? ren1   : ren0;
    assign d_valid = sel ? valid1 : valid0;
    assign d_last  = sel ? last1  : last0;
    assign d_done  = sel ? done1  : done0;
    assign d_addr  = sel ? addr1  : addr0;
    assign d_data  = sel ? data1  : data0;
    assign d_sum   = sel ? sum1   : sum0;

    int   errors = 0;
    int   checks = 0;
    vec_t tbl0 [$];
    vec_t tbl1 [$];
    vec_t tbl  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_ps(input logic v);
        if (sel) ps1 = v;
        else     ps0 = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_sel"},   32'(d_sel),   32'd0);
        check({tag, "_ren"},   32'(d_ren),   32'd0);
        check({tag, "_addr"},  32'(d_addr),  32'd0);
        check({tag, "_data"},  32'(d_data),  32'd0);
        check({tag, "_valid"}, 32'(d_valid), 32'd0);
        check({tag, "_last"},  32'(d_last),  32'd0);
        check({tag, "_done"},  32'(d_done),  32'd0);
        check({tag, "_sum"},   32'(d_sum),   32'd0);
    endtask

    // Follow one dump against tbl: read addresses, word order, last flag,
    // hold-while-stalled and first-valid latency (counted from proc_state rise).
    task automatic stream(input int n, input bit toggle, input bit pulse);
        int         k = 0;
        int         a = 0;
        int         cyc = 0;
        int         first = -1;
        bit         stalled = 0;
        logic [7:0] hold_d = '0;
        logic       hold_l = 1'b0;
        logic [3:0] pat = 4'b1001;
        ready = toggle ? pat[0] : 1'b1;
        while (k < n && cyc < 2000) begin
            if (d_ren) begin
                if (a < n) check("addr", 32'(d_addr), 32'(tbl[a].addr));
                else       check("extra_read", 32'(a), 32'(n));
                a++;
            end
            if (stalled) begin
                check("stall_valid", 32'(d_valid), 32'd1);
                check("stall_data",  32'(d_data),  32'(hold_d));
                check("stall_last",  32'(d_last),  32'(hold_l));
                check("stall_ren",   32'(d_ren),   32'd0);
            end
            if (d_valid) begin
                if (first < 0) first = cyc;
                if (ready) begin
                    check("data", 32'(d_data), 32'(tbl[k].data));
                    check("last", 32'(d_last), 32'(tbl[k].last));
                    k++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    hold_d  = d_data;
                    hold_l  = d_last;
                end
            end else begin
                stalled = 0;
            end
            tick();
            cyc++;
            if (pulse && cyc == 1) set_ps(1'b0);
            ready = toggle ? pat[cyc % 4] : 1'b1;
        end
        check("words_streamed", 32'(k), 32'(n));
        check("reads_issued", 32'(a), 32'(n));
        check("first_valid_latency", 32'(first), 32'd3);
    endtask

    task automatic check_done(input logic [7:0] exp_sum);
        check("done_flag",  32'(d_done),  32'd1);
        check("done_sum",   32'(d_sum),   32'(exp_sum));
        check("done_valid", 32'(d_valid), 32'd0);
        check("done_sel",   32'(d_sel),   32'd0);
        check("done_last",  32'(d_last),  32'd0);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < 256; i++) begin
            mem0[i] = (i < 16) ? 8'(8'h10 + i) : 8'hEE;
            mem1[i] = 8'h55;
        end
        mem1[254] = 8'hAA;
        mem1[255] = 8'hBB;
        mem1[0]   = 8'hCC;
        mem1[1]   = 8'hDD;
        for (int i = 0; i < 16; i++) tbl0.push_back('{8'(i), 8'(8'h10 + i), (i == 15)});
        tbl1.push_back('{8'hFE, 8'hAA, 1'b0});
        tbl1.push_back('{8'hFF, 8'hBB, 1'b0});
        tbl1.push_back('{8'h00, 8'hCC, 1'b0});
        tbl1.push_back('{8'h01, 8'hDD, 1'b1});

        // Reset state.
        sel = 1'b0; ps0 = 1'b0; ps1 = 1'b0; ready = 1'b1; rst_n = 1'b0;
        #12;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        // Basic full dump, ready held high, then DONE holds while halted.
        tbl = tbl0;
        ps0 = 1'b1;
        stream(16, 1'b0, 1'b0);
        check_done(8'h78);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("done_hold", 32'(d_done), 32'd1);
            check("done_hold_ren", 32'(d_ren), 32'd0);
        end

        // Re-arm by dropping proc_state for one cycle, then a stalled second dump.
        ps0 = 1'b0;
        tick();
        check_idle_outputs("rearm");
        ps0 = 1'b1;
        stream(16, 1'b1, 1'b0);
        check_done(8'h78);

        // Asynchronous reset while word 5 is on the output.
        ps0 = 1'b0;
        tick();
        ps0 = 1'b1;
        ready = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            if (d_valid && d_data == 8'h15) found = 1;
        end
        check("reach_word5", 32'(found), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        tick();
        rst_n = 1'b1;
        stream(16, 1'b0, 1'b0);
        check_done(8'h78);

        // Single-cycle proc_state pulse still yields a full dump, then back to IDLE.
        ps0 = 1'b0;
        tick();
        ps0 = 1'b1;
        stream(16, 1'b0, 1'b1);
        check_done(8'h78);
        tick();
        check("pulse_done_clear", 32'(d_done), 32'd0);
        check("pulse_sel", 32'(d_sel), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("pulse_no_redump", 32'(d_ren), 32'd0);
        end

        // Address wrap instance.
        sel = 1'b1;
        tbl = tbl1;
        ps1 = 1'b1;
        stream(4, 1'b0, 1'b0);
        check_done(8'h0E);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
